dot_product_seq: RTL
====================

# dot_product_seq

Sequencing front-end for the shift-add `multiplier`. It accepts a stream of operand pairs over a valid/ready handshake and issues one multiplication at a time on the multiplier's start/finished interface. It sums the products into a wide accumulator and presents the dot product after the pair flagged last. The block sits directly upstream of the multiplier, which it feeds, and directly downstream of it, since it consumes `out_prod`.

## Interface
- `IN_BITS`, 8: operand width; must match the multiplier's `IN_BITS`.
- `OUT_BITS`, 16: product width; must match the multiplier's `OUT_BITS`.
- `ACC_BITS`, 24: accumulator width; must be ≥ `OUT_BITS`.
- `CNT_BITS`, 8: term-counter width.
- `in_clk` in 1: system clock; all state changes on the rising edge.
- `in_rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_a`, `in_b` in `IN_BITS`: operands, unsigned.
- `in_last` in 1: this pair ends the vector.
- `out_ready` out 1: pair accepted on an edge where `in_valid && out_ready`.
- `out_mult_a`, `out_mult_b` out `IN_BITS`: operands to the multiplier.
- `out_mult_start` out 1: multiplier start.
- `in_mult_finished` in 1: multiplier finished.
- `in_mult_prod` in `OUT_BITS`: multiplier product.
- `out_valid` out 1: `out_sum` and `out_count` are valid.
- `out_sum` out `ACC_BITS`: dot product.
- `out_count` out `CNT_BITS`: number of terms summed, modulo 2^`CNT_BITS`.
- `out_ovf` out 1: sticky accumulator-overflow flag for the current vector.
- `in_ack` in 1: consumer takes the result.

## Operation
- The state register has five states: IDLE, START, WAIT, ACCUM, DONE. On reset the state is IDLE and every output is 0 except `out_ready`, which is 1.
- **IDLE**
  - `out_ready` = 1.
  - On `in_valid`: latch `in_a`/`in_b` into `out_mult_a`/`out_mult_b`, latch `in_last`, then go to START.
- **START**
  - `out_mult_start` = 1 for exactly this one cycle.
  - Go to WAIT and clear the guard bit.
  - Operands stay stable from START until ACCUM.
- **WAIT**
  - In the first WAIT cycle `in_mult_finished` is ignored (guard bit set), because it may still show the previous operation's finished flag.
  - From the second WAIT cycle onward, an edge with `in_mult_finished` = 1 latches `in_mult_prod` and the state goes to ACCUM.
  - There is no timeout.
- **ACCUM**
  - `acc <= acc + zero_extend(prod)`; `count <= count + 1`.
  - A carry out of `ACC_BITS` sets `out_ovf`.
  - Next state is DONE if the latched `last` = 1, otherwise IDLE.
- **DONE**
  - `out_valid` = 1; `out_sum` = acc; `out_count` = count; `out_ready` = 0.
  - On `in_ack`: clear acc, count and `out_ovf`, then go to IDLE.
  - The result is held indefinitely until `in_ack`.
- `in_ack` outside DONE is ignored. `in_valid` outside IDLE is not accepted; the producer must hold the pair.
- Reset asserted in any state returns to IDLE immediately (asynchronous).
  - `out_mult_start` drops at once.
  - The partial sum is discarded.

## Timing
- Handshake on edge T puts START in cycle T+1 and WAIT from T+2. `in_mult_finished` is first honoured in cycle T+3.
- `in_mult_finished` sampled on edge F puts ACCUM in cycle F+1.
  - Next pair: `out_ready` high again in cycle F+2.
  - Last pair: `out_valid` high in cycle F+2.
- Minimum spacing between accepted pairs is 4 cycles plus the multiplier latency.
- `out_ready`, `out_mult_start` and `out_valid` are decoded from the registered state only; they have no combinational path from inputs.

## Configuration
- `DOT_PRODUCT_SATURATE_EN`
  - Defined: when the add overflows, acc clamps to 2^`ACC_BITS`−1, stays clamped for the rest of the vector, and `out_ovf` is set.
  - Undefined: acc wraps modulo 2^`ACC_BITS` and `out_ovf` is set.

## Test plan
- Single term: (123, 234, last=1) → `out_sum` = 28782, `out_count` = 1, `out_ovf` = 0; `out_valid` held until `in_ack`, then `out_ready` = 1.
- Vector: (3,4), (5,6), (7,8, last) → `out_sum` = 98, `out_count` = 3; `out_mult_start` high exactly one cycle per pair.
- Overflow with `ACC_BITS` = 16: (255,255), (255,255, last).
  - Macro undefined → `out_sum` = 64514, `out_ovf` = 1.
  - Macro defined → `out_sum` = 65535, `out_ovf` = 1.
- Stale finished: `in_mult_finished` held high entering WAIT → the first WAIT cycle is not accepted; the product is latched only on a later cycle.
- Back-pressure:
  - `in_valid` held during DONE → no acceptance.
  - `in_ack` delayed 10 cycles → `out_sum` stable throughout.
  - After ack, the next vector starts from 0.
- Reset pulse while in WAIT mid-vector → all outputs take their reset values immediately; a fresh (2, 3, last) then yields `out_sum` = 6, `out_count` = 1.

Source files
------------

// File: rtl/dot_product_seq.sv
// dot_product_seq
//
// Sequencing front-end for a start/finished shift-add multiplier. Operand
// pairs arrive over a valid/ready handshake, are issued to the multiplier one
// at a time, and their products are summed into a wide accumulator. After the
// pair flagged last, the dot product is held on out_sum until in_ack.
//
// Ports
//   in_clk, in_rst              clock, asynchronous active-low reset
//   in_valid, in_a, in_b,
//   in_last, out_ready          operand-pair handshake (accept on valid&&ready)
//   out_mult_a, out_mult_b,
//   out_mult_start              operands and one-cycle start to the multiplier
//   in_mult_finished,
//   in_mult_prod                multiplier completion flag and product
//   out_valid, out_sum,
//   out_count, out_ovf, in_ack  result, term count, sticky overflow, consume
//
// Configuration
//   DOT_PRODUCT_SATURATE_EN     defined: accumulator clamps to all-ones on
//                               overflow; undefined: accumulator wraps.
//                               out_ovf is set on overflow either way.

module dot_product_seq #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 16,
  parameter int ACC_BITS = 24,
  parameter int CNT_BITS = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_a,
  input  logic [IN_BITS-1:0]  in_b,
  input  logic                in_last,
  output logic                out_ready,
  output logic [IN_BITS-1:0]  out_mult_a,
  output logic [IN_BITS-1:0]  out_mult_b,
  output logic                out_mult_start,
  input  logic                in_mult_finished,
  input  logic [OUT_BITS-1:0] in_mult_prod,
  output logic                out_valid,
  output logic [ACC_BITS-1:0] out_sum,
  output logic [CNT_BITS-1:0] out_count,
  output logic                out_ovf,
  input  logic                in_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [IN_BITS-1:0]    a_reg, b_reg;
  logic                  last_reg;
  // Cleared in START; set after the first WAIT cycle. The finished flag is
  // only trusted once armed, since the multiplier may still be showing the
  // previous operation's completion during the first WAIT cycle.
  logic                  armed_reg;
  logic [OUT_BITS-1:0]   prod_reg;
  logic [ACC_BITS-1:0]   acc_reg, acc_next;
  logic [CNT_BITS-1:0]   count_reg;
  logic                  ovf_reg, ovf_next;
  logic [ACC_BITS:0]     sum_wide;

  // State register
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded handshake outputs. The outputs depend on
  // state_reg only, so no input reaches them combinationally.
  always_comb begin
    state_next     = state_reg;
    out_ready      = 1'b0;
    out_mult_start = 1'b0;
    out_valid      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        out_ready = 1'b1;
        if (in_valid) state_next = ST_START;
      end
      ST_START: begin
        out_mult_start = 1'b1;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (armed_reg && in_mult_finished) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        state_next = last_reg ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (in_ack) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Accumulator update: one extra bit captures the carry out of ACC_BITS.
  always_comb begin
    sum_wide = {1'b0, acc_reg} + {{(ACC_BITS + 1 - OUT_BITS){1'b0}}, prod_reg};
    ovf_next = ovf_reg | sum_wide[ACC_BITS];
`ifdef DOT_PRODUCT_SATURATE_EN
    // Once the vector has overflowed the sum stays pinned at full scale.
    if (ovf_next) begin
      acc_next = '1;
    end else begin
      acc_next = sum_wide[ACC_BITS-1:0];
    end
`else
    acc_next = sum_wide[ACC_BITS-1:0];
`endif
  end

  // Datapath registers
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      last_reg  <= 1'b0;
      armed_reg <= 1'b0;
      prod_reg  <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            last_reg <= in_last;
          end
        end
        ST_START: begin
          armed_reg <= 1'b0;
        end
        ST_WAIT: begin
          if (!armed_reg) begin
            armed_reg <= 1'b1;
          end else if (in_mult_finished) begin
            prod_reg <= in_mult_prod;
          end
        end
        ST_ACCUM: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + CNT_BITS'(1);
          ovf_reg   <= ovf_next;
        end
        ST_DONE: begin
          if (in_ack) begin
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_mult_a = a_reg;
  assign out_mult_b = b_reg;
  assign out_sum    = acc_reg;
  assign out_count  = count_reg;
  assign out_ovf    = ovf_reg;

endmodule
